// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory port responder.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      RAM,
      MMIO_GPIO,
      MMIO_CYCLE,
      ERR
   } decode_t;

   localparam logic [31:0] GPIO_ADDR  = 32'hFFFF_0000;
   localparam logic [31:0] CYCLE_ADDR = 32'hFFFF_0004;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory port and mem_responder.
interface mem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_responder_ram.sv
// Single-port word RAM with a one-cycle registered read; contents survive reset.
module mem_responder_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder with RAM and an optional register window
// (MEM_RESPONDER_MMIO_EN: GPIO register and free-running cycle counter).
//
// state | meaning
// IDLE  | ready for a request; accept captures we/addr/wdata
// WAIT  | wait counter running; leaves on the 1->0 step
// RESP  | one-cycle response strobe, then back to IDLE
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_responder_if.slave    bus,
   output logic [31:0]       gpio_out
);

   localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
   localparam logic [32:0] RAM_BYTES = 33'd4 << ADDR_W;

   function automatic decode_t decode(input logic [31:0] a);
      if (a[1:0] != 2'b00) return ERR;
      if ({1'b0, a} < RAM_BYTES) return RAM;
`ifdef MEM_RESPONDER_MMIO_EN
      if (a == GPIO_ADDR) return MMIO_GPIO;
      if (a == CYCLE_ADDR) return MMIO_CYCLE;
`endif
      return ERR;
   endfunction

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   decode_t     dec_q;

   logic        cur_we;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   decode_t     cur_dec;
   logic        commit;
   logic [31:0] ram_rdata;
   logic [31:0] gpio_q;
   logic [31:0] cycle_q;

   // In IDLE the live request feeds RAM/decode so a zero-wait access completes on the accept edge.
   always_comb begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      if (state == IDLE) begin
         cur_we    = bus.req_we;
         cur_addr  = bus.req_addr;
         cur_wdata = bus.req_wdata;
      end
   end

   assign cur_dec = decode(cur_addr);
   assign commit  = (state == IDLE) ? (bus.req_valid && NO_WAIT)
                                    : ((state == WAIT) && (wait_cnt == 4'd1));

   mem_responder_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (commit && cur_we && (cur_dec == RAM)),
      .addr  (cur_addr[ADDR_W+1:2]),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         dec_q    <= ERR;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  dec_q   <= cur_dec;
                  if (NO_WAIT) begin
                     state <= RESP;
                  end else begin
                     wait_cnt <= WAIT_LOAD;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_RESPONDER_MMIO_EN
   // The cycle counter is read-only: writes to its address complete without error or effect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpio_q  <= '0;
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (commit && cur_we && (cur_dec == MMIO_GPIO)) gpio_q <= cur_wdata;
      end
   end
`else
   assign gpio_q  = '0;
   assign cycle_q = '0;
`endif

   assign gpio_out       = gpio_q;
   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_err   = (state == RESP) && (dec_q == ERR);

   always_comb begin
      bus.resp_rdata = '0;
      if ((state == RESP) && !we_q) begin
         case (dec_q)
            RAM:        bus.resp_rdata = ram_rdata;
            MMIO_GPIO:  bus.resp_rdata = gpio_q;
            MMIO_CYCLE: bus.resp_rdata = cycle_q;
            default:    bus.resp_rdata = '0;
         endcase
      end
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder for the multicycle core's memory port. Accepts one read or write request at a time through a valid/ready handshake and inserts a configurable number of wait states. Returns read data with a one-cycle response strobe and flags misaligned or unmapped accesses. Sits between the core's address/data mux and the backing RAM, with an optional memory-mapped register window.

## Interface
Parameters:
- ADDR_W, 8, word-address bits; RAM depth = 2**ADDR_W words; byte range 0 .. 4*2**ADDR_W-1
- WAIT_CYCLES, 2, wait states inserted per transaction (0..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present; requester holds all req_* stable until accepted
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_ready  out  1  responder idle; handshake completes on edge with req_valid & req_ready
- resp_valid  out  1  one-cycle strobe, transaction complete
- resp_rdata  out  32  read data; valid only while resp_valid; 0 for writes and errors
- resp_err  out  1  qualified by resp_valid; misaligned or unmapped access
- gpio_out  out  32  MMIO output register (constant 0 when MMIO compiled out)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On accept, capture we/addr/wdata. If WAIT_CYCLES=0, go to RESP; otherwise load the wait counter with WAIT_CYCLES and go to WAIT.
- WAIT: req_ready=0. Counter decrements each cycle. Leave for RESP on the edge where the counter goes 1->0.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0. Next state is always IDLE.
- Decode from the captured address:
  - addr[1:0]!=0 -> error.
  - addr < 4*2**ADDR_W -> RAM.
  - MMIO hits (when enabled) -> register.
  - Anything else -> error.
- Write side effects commit on the edge entering RESP.
- Error transaction: no side effect, resp_rdata=0, resp_err=1.
- Read data reflects all previously completed writes.
- req_valid while req_ready=0 is ignored; no queuing.
- Reset values: state IDLE, req_ready=1 after reset release, resp_valid=0, resp_rdata=0, resp_err=0, gpio_out=0, cycle counter=0.
- RAM contents are not cleared by reset.
- Reset mid-transaction aborts it: no response is issued, and a pending write is dropped unless its commit edge has already occurred.

## Timing
- Accept edge T0; resp_valid high during cycle T0+WAIT_CYCLES+1 (one cycle after T0 when WAIT_CYCLES=0).
- Next accept earliest on the edge ending the RESP cycle is not allowed; earliest accept is the first IDLE edge.
- Throughput: one transaction per WAIT_CYCLES+2 cycles.
- RAM has a 1-cycle synchronous read. With WAIT_CYCLES=0, the RAM address is driven from req_addr during the accepting IDLE cycle so data is ready in RESP.
- Outputs are registered or decoded from state only; there is no combinational path from req_* to any output.

## Configuration
- MEM_RESPONDER_MMIO_EN defined: register window active.
  - 0xFFFF_0000: GPIO register, R/W, drives gpio_out.
  - 0xFFFF_0004: free-running 32-bit cycle counter, increments every clk, wraps 0xFFFF_FFFF->0. Read-only; writes are ignored without error.
- Undefined: both addresses decode as unmapped -> resp_err=1; gpio_out tied 0; no counter logic.

## Structure
- Shared package mem_responder_pkg:
  - FSM state enum.
  - MMIO address constants (GPIO_ADDR, CYCLE_ADDR).
  - Decode-result enum (RAM, MMIO_GPIO, MMIO_CYCLE, ERR).
- One sub-module: mem_responder_ram, single-port synchronous RAM with write enable, 32-bit data, ADDR_W address.
- FSM, decode and MMIO live in the top module.

## Test plan
- Reset then write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 (WAIT_CYCLES=2) -> resp_valid 3 cycles after each accept, rdata=0xDEADBEEF, resp_err=0.
- Read 0x0000_0012 (misaligned), then write 0x1 to 0x0000_0012 -> resp_err=1 and rdata=0 for both; word 0x10 still reads 0xDEADBEEF.
- Read 0x0000_0400 (ADDR_W=8, out of range) -> resp_err=1, rdata=0.
- MMIO_EN: write 0x0000_00A5 to 0xFFFF_0000 -> gpio_out=0x0000_00A5 in the RESP cycle. Two reads of 0xFFFF_0004 -> difference equals cycles between the accepts. Without the macro: resp_err=1, gpio_out=0.
- WAIT_CYCLES=0 back-to-back reads of words 0..3 -> resp_valid every 2nd cycle with correct data; req_valid held during RESP is not accepted until IDLE.
- Assert rst_n low during WAIT of a write to 0x20 -> no resp_valid, req_ready=1 after release, word 0x20 unchanged.
